// File: rtl/dcache_sa.sv
// dcache_sa: N-way set-associative, write-back, write-allocate data cache.
//
// Sits between the CPU load/store port and a single-ported word SRAM.
// Lines hold LINE_WORDS 32-bit words; replacement is true LRU using a
// per-set permutation of ages (0 = most recently used). A dirty victim is
// burst-written back before the line fill.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   address         CPU byte address (bits [1:0] ignored)
//   data_in_cpu     store data
//   rd              load request
//   wr              store byte enables (nonzero = store, wins over rd)
//   hit_miss        1 = request hit on first lookup (valid with data_ready)
//   data2cpu        load data (valid with data_ready)
//   data_ready      one-cycle completion pulse
//   data_in_mem     SRAM read data, valid one cycle after mrden
//   data2mem        write-back data
//   m_rd_address    SRAM read byte address (word aligned)
//   m_wr_address    SRAM write byte address (word aligned)
//   mrden, mwren    SRAM read / write enables (never both high)
//   stat_hits, stat_misses, stat_wbs  (only with DCACHE_SA_STATS_EN)
//
// Optional build macro: DCACHE_SA_STATS_EN adds 32-bit event counters for
// first-lookup hits, first-lookup misses and write-back bursts.

module dcache_sa #(
  parameter int ADDR_W     = 16,
  parameter int SETS       = 64,
  parameter int WAYS       = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in_cpu,
  input  logic              rd,
  input  logic [3:0]        wr,
  output logic              hit_miss,
  output logic [31:0]       data2cpu,
  output logic              data_ready,
  input  logic [31:0]       data_in_mem,
  output logic [31:0]       data2mem,
  output logic [ADDR_W-1:0] m_rd_address,
  output logic [ADDR_W-1:0] m_wr_address,
  output logic              mrden,
  output logic              mwren
`ifdef DCACHE_SA_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
  output logic [31:0]       stat_wbs
`endif
);

  // Field widths. The *_BITS values are the true field sizes (may be 0);
  // the *_W values are storage widths and never drop below 1.
  localparam int WORD_BITS = $clog2(LINE_WORDS);
  localparam int IDX_BITS  = $clog2(SETS);
  localparam int WAY_BITS  = $clog2(WAYS);
  localparam int WORD_W    = (WORD_BITS > 0) ? WORD_BITS : 1;
  localparam int IDX_W     = (IDX_BITS > 0) ? IDX_BITS : 1;
  localparam int WAY_W     = (WAY_BITS > 0) ? WAY_BITS : 1;
  localparam int AGE_W     = WAY_W;
  localparam int IDX_SH    = 2 + WORD_BITS;
  localparam int TAG_SH    = IDX_SH + IDX_BITS;
  localparam int TAG_W     = ADDR_W - TAG_SH;
  localparam int SW        = SETS * WAYS;
  localparam int SW_W      = ($clog2(SW) > 0) ? $clog2(SW) : 1;
  localparam int DA        = SW * LINE_WORDS;
  localparam int DA_W      = ($clog2(DA) > 0) ? $clog2(DA) : 1;
  localparam int CNT_W     = $clog2(LINE_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_FILL,
    S_DONE
  } state_t;

  // Storage: tags and data live in RAM arrays; control bits are flops so
  // they can be cleared by reset.
  logic [TAG_W-1:0] tag_mem  [SW];
  logic [31:0]      data_mem [DA];
  logic [SETS-1:0][WAYS-1:0]             valid_reg;
  logic [SETS-1:0][WAYS-1:0]             dirty_reg;
  logic [SETS-1:0][WAYS-1:0][AGE_W-1:0]  age_reg;

  state_t              state_reg;
  logic [ADDR_W-1:0]   req_addr_reg;
  logic [31:0]         req_data_reg;
  logic [3:0]          req_wr_reg;
  logic                missed_reg;
  logic [WAY_W-1:0]    victim_reg;
  logic [TAG_W-1:0]    victim_tag_reg;
  logic [CNT_W-1:0]    cnt_reg;

  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    req_idx;
  logic [WORD_W-1:0]   req_word;
  logic                req_store;

  logic [WAYS-1:0]     way_hit;
  logic [WAYS-1:0]     way_valid;
  logic [TAG_W-1:0]    way_tag [WAYS];
  logic                hit;
  logic [WAY_W-1:0]    hit_way;
  logic [WAY_W-1:0]    victim_way;
  logic                victim_found;

  logic [WAY_W-1:0]    rd_way;
  logic [WORD_W-1:0]   rd_word;
  logic [31:0]         rd_data;

  logic                dm_we;
  logic [DA_W-1:0]     dm_idx;
  logic [31:0]         dm_wdata;
  logic                tm_we;
  logic [SW_W-1:0]     tm_idx;

  function automatic logic [SW_W-1:0] sw_idx(input logic [IDX_W-1:0] s,
                                             input logic [WAY_W-1:0] w);
    return SW_W'(int'(s) * WAYS + int'(w));
  endfunction

  function automatic logic [DA_W-1:0] da_idx(input logic [IDX_W-1:0] s,
                                             input logic [WAY_W-1:0] w,
                                             input logic [WORD_W-1:0] k);
    return DA_W'((int'(s) * WAYS + int'(w)) * LINE_WORDS + int'(k));
  endfunction

  // {tag, index, word, 2'b00}, built with shifts so zero-width fields work.
  function automatic logic [ADDR_W-1:0] build_addr(input logic [TAG_W-1:0] t,
                                                   input logic [IDX_W-1:0] s,
                                                   input logic [WORD_W-1:0] k);
    return (ADDR_W'(t) << TAG_SH) | (ADDR_W'(s) << IDX_SH) | (ADDR_W'(k) << 2);
  endfunction

  assign req_tag   = TAG_W'(req_addr_reg >> TAG_SH);
  assign req_idx   = IDX_W'((req_addr_reg >> IDX_SH) & ADDR_W'(SETS - 1));
  assign req_word  = WORD_W'((req_addr_reg >> 2) & ADDR_W'(LINE_WORDS - 1));
  assign req_store = (req_wr_reg != 4'd0);

  // Per-way tag compare for the requested set.
  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      assign way_tag[gi]   = tag_mem[sw_idx(req_idx, WAY_W'(gi))];
      assign way_valid[gi] = valid_reg[req_idx][gi];
      assign way_hit[gi]   = way_valid[gi] && (way_tag[gi] == req_tag);
    end
  endgenerate

  assign hit = |way_hit;

  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_hit[w]) hit_way = WAY_W'(w);
    end
  end

  // Victim: lowest-index invalid way, otherwise the oldest (age WAYS-1).
  always_comb begin
    victim_way   = '0;
    victim_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!victim_found && !way_valid[w]) begin
        victim_way   = WAY_W'(w);
        victim_found = 1'b1;
      end
    end
    if (!victim_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_reg[req_idx][w] == AGE_W'(WAYS - 1)) victim_way = WAY_W'(w);
      end
    end
  end

  // Single data read port. In LOOKUP it serves either the hit word or word 0
  // of the victim (first write-back beat); in WB it prefetches the next beat.
  always_comb begin
    rd_way  = victim_reg;
    rd_word = WORD_W'(cnt_reg + CNT_W'(1));
    if (state_reg == S_LOOKUP) begin
      if (hit) begin
        rd_way  = hit_way;
        rd_word = req_word;
      end else begin
        rd_way  = victim_way;
        rd_word = '0;
      end
    end
  end

  assign rd_data = data_mem[da_idx(req_idx, rd_way, rd_word)];

  // Data/tag write port: store merge on a hit, word capture during a fill,
  // tag install after the last captured word.
  always_comb begin
    dm_we    = 1'b0;
    dm_idx   = da_idx(req_idx, rd_way, rd_word);
    dm_wdata = rd_data;
    tm_we    = 1'b0;
    tm_idx   = sw_idx(req_idx, victim_reg);
    if (state_reg == S_LOOKUP && hit && req_store) begin
      dm_we = 1'b1;
      for (int b = 0; b < 4; b++) begin
        if (req_wr_reg[b]) dm_wdata[8*b +: 8] = req_data_reg[8*b +: 8];
      end
    end else if (state_reg == S_FILL && cnt_reg != '0) begin
      dm_we    = 1'b1;
      dm_idx   = da_idx(req_idx, victim_reg, WORD_W'(cnt_reg - CNT_W'(1)));
      dm_wdata = data_in_mem;
      tm_we    = (cnt_reg == CNT_W'(LINE_WORDS));
    end
  end

  always_ff @(posedge clk) begin
    if (dm_we) data_mem[dm_idx] <= dm_wdata;
    if (tm_we) tag_mem[tm_idx] <= req_tag;
  end

  // Main controller.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      valid_reg      <= '0;
      dirty_reg      <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          age_reg[s][w] <= AGE_W'(w);
        end
      end
      req_addr_reg   <= '0;
      req_data_reg   <= '0;
      req_wr_reg     <= '0;
      missed_reg     <= 1'b0;
      victim_reg     <= '0;
      victim_tag_reg <= '0;
      cnt_reg        <= '0;
      hit_miss       <= 1'b0;
      data2cpu       <= '0;
      data_ready     <= 1'b0;
      data2mem       <= '0;
      m_rd_address   <= '0;
      m_wr_address   <= '0;
      mrden          <= 1'b0;
      mwren          <= 1'b0;
`ifdef DCACHE_SA_STATS_EN
      stat_hits      <= '0;
      stat_misses    <= '0;
      stat_wbs       <= '0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (wr != 4'd0 || rd) begin
            req_addr_reg <= address;
            req_data_reg <= data_in_cpu;
            req_wr_reg   <= wr;
            missed_reg   <= 1'b0;
            state_reg    <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          if (hit) begin
            // Hit way becomes MRU; ways younger than it age by one.
            for (int w = 0; w < WAYS; w++) begin
              if (WAY_W'(w) == hit_way) begin
                age_reg[req_idx][w] <= '0;
              end else if (age_reg[req_idx][w] < age_reg[req_idx][hit_way]) begin
                age_reg[req_idx][w] <= age_reg[req_idx][w] + AGE_W'(1);
              end
            end
            if (req_store) begin
              dirty_reg[req_idx][hit_way] <= 1'b1;
            end else begin
              data2cpu <= rd_data;
            end
            data_ready <= 1'b1;
            hit_miss   <= ~missed_reg;
            state_reg  <= S_DONE;
`ifdef DCACHE_SA_STATS_EN
            if (!missed_reg) stat_hits <= stat_hits + 32'd1;
`endif
          end else begin
            missed_reg     <= 1'b1;
            victim_reg     <= victim_way;
            victim_tag_reg <= way_tag[victim_way];
            cnt_reg        <= '0;
`ifdef DCACHE_SA_STATS_EN
            if (!missed_reg) stat_misses <= stat_misses + 32'd1;
`endif
            if (way_valid[victim_way] && dirty_reg[req_idx][victim_way]) begin
              mwren        <= 1'b1;
              m_wr_address <= build_addr(way_tag[victim_way], req_idx, '0);
              data2mem     <= rd_data;
              state_reg    <= S_WB;
`ifdef DCACHE_SA_STATS_EN
              stat_wbs     <= stat_wbs + 32'd1;
`endif
            end else begin
              mrden        <= 1'b1;
              m_rd_address <= build_addr(req_tag, req_idx, '0);
              state_reg    <= S_FILL;
            end
          end
        end

        S_WB: begin
          if (cnt_reg == CNT_W'(LINE_WORDS - 1)) begin
            mwren        <= 1'b0;
            mrden        <= 1'b1;
            m_rd_address <= build_addr(req_tag, req_idx, '0);
            cnt_reg      <= '0;
            state_reg    <= S_FILL;
          end else begin
            cnt_reg      <= cnt_reg + CNT_W'(1);
            m_wr_address <= build_addr(victim_tag_reg, req_idx,
                                       WORD_W'(cnt_reg + CNT_W'(1)));
            data2mem     <= rd_data;
          end
        end

        S_FILL: begin
          // cnt_reg counts edges spent in FILL: read k is issued for
          // cnt_reg = k-1 and its data is captured when cnt_reg = k+1.
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (int'(cnt_reg) + 1 < LINE_WORDS) begin
            mrden        <= 1'b1;
            m_rd_address <= build_addr(req_tag, req_idx,
                                       WORD_W'(cnt_reg + CNT_W'(1)));
          end else begin
            mrden <= 1'b0;
          end
          if (cnt_reg == CNT_W'(LINE_WORDS)) begin
            valid_reg[req_idx][victim_reg] <= 1'b1;
            dirty_reg[req_idx][victim_reg] <= 1'b0;
            state_reg                      <= S_LOOKUP;
          end
        end

        S_DONE: begin
          data_ready <= 1'b0;
          state_reg  <= S_IDLE;
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_sa.sv
// tb_dcache_sa: self-checking bench for dcache_sa (default parameters).
//
// The reference is a transparent-memory view: a golden word array holds the
// value every address must read back, and a per-set residency table with
// recency stamps predicts hit/miss, evictions, write-back traffic and
// latency. A behavioural SRAM backs the cache, preloaded with mem[a] = a.
// Define DCACHE_SA_STATS_EN to also check the event counters.

module tb_dcache_sa;

  localparam int MEMW = 16384;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] address;
  logic [31:0] data_in_cpu;
  logic        rd;
  logic [3:0]  wr;
  logic        hit_miss;
  logic [31:0] data2cpu;
  logic        data_ready;
  logic [31:0] data_in_mem;
  logic [31:0] data2mem;
  logic [15:0] m_rd_address;
  logic [15:0] m_wr_address;
  logic        mrden;
  logic        mwren;
`ifdef DCACHE_SA_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_wbs;
`endif

  dcache_sa dut (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .data_in_cpu  (data_in_cpu),
    .rd           (rd),
    .wr           (wr),
    .hit_miss     (hit_miss),
    .data2cpu     (data2cpu),
    .data_ready   (data_ready),
    .data_in_mem  (data_in_mem),
    .data2mem     (data2mem),
    .m_rd_address (m_rd_address),
    .m_wr_address (m_wr_address),
    .mrden        (mrden),
    .mwren        (mwren)
`ifdef DCACHE_SA_STATS_EN
    ,
    .stat_hits    (stat_hits),
    .stat_misses  (stat_misses),
    .stat_wbs     (stat_wbs)
`endif
  );

  always #5 clk = ~clk;

  // Backing SRAM: read data appears the cycle after mrden.
  logic [31:0] sram [MEMW];
  always @(posedge clk) begin
    if (mrden) data_in_mem <= sram[m_rd_address[15:2]];
    if (mwren) sram[m_wr_address[15:2]] <= data2mem;
  end

  // Bus monitor, sampled on the falling edge.
  logic [15:0] rq[$];
  logic [15:0] wq[$];
  logic [31:0] wdq[$];
  bit          both_seen;
  always @(negedge clk) begin
    if (mrden) rq.push_back(m_rd_address);
    if (mwren) begin
      wq.push_back(m_wr_address);
      wdq.push_back(data2mem);
    end
    if (mrden && mwren) both_seen = 1'b1;
  end

  // Reference model.
  logic [31:0] gm [MEMW];
  bit          m_vld   [64][4];
  bit          m_dirty [64][4];
  int          m_tag   [64][4];
  int          m_stamp [64][4];
  int          stamp_ctr;
  int          txn;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 64; s++) begin
      for (int w = 0; w < 4; w++) begin
        m_vld[s][w]   = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_tag[s][w]   = 0;
        m_stamp[s][w] = 0;
      end
    end
  endtask

  task automatic do_req(input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic rdq, input string name);
    int s, t, slot, lat_exp, n, gw;
    bit is_store, exp_hit, exp_wb, done;
    logic [15:0] line_a, vline_a;
    logic [31:0] exp_data;
    s        = int'((a >> 4) & 16'h3F);
    t        = int'(a >> 10);
    gw       = int'(a >> 2);
    line_a   = a & 16'hFFF0;
    is_store = (be != 4'd0);
    exp_data = gm[gw];
    exp_hit  = 1'b0;
    exp_wb   = 1'b0;
    slot     = -1;
    vline_a  = '0;
    for (int w = 0; w < 4; w++)
      if (m_vld[s][w] && m_tag[s][w] == t) begin exp_hit = 1'b1; slot = w; end
    if (!exp_hit) begin
      for (int w = 3; w >= 0; w--) if (!m_vld[s][w]) slot = w;
      if (slot < 0) begin
        slot = 0;
        for (int w = 1; w < 4; w++) if (m_stamp[s][w] < m_stamp[s][slot]) slot = w;
        exp_wb  = m_dirty[s][slot];
        vline_a = 16'((m_tag[s][slot] << 10) | (s << 4));
      end
    end
    lat_exp = exp_hit ? 1 : (exp_wb ? 11 : 7);

    rq.delete(); wq.delete(); wdq.delete(); both_seen = 1'b0;
    @(negedge clk);
    address = a; data_in_cpu = d; wr = be; rd = rdq;
    n = 0; done = 1'b0;
    while (!done && n < 64) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (data_ready) done = 1'b1;
    end
    rd = 1'b0; wr = 4'd0;
    txn++;
    $display("txn %0d %s addr=%04h be=%b rd=%b hm=%0b lat=%0d data=%08h",
             txn, name, a, be, rdq, hit_miss, n - 1, data2cpu);
    if (!done) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({name, "_latency"}, n - 1, lat_exp);
    check({name, "_hit_miss"}, {31'd0, hit_miss}, {31'd0, exp_hit});
    if (!is_store) check({name, "_data2cpu"}, data2cpu, exp_data);
    check({name, "_rd_beats"}, rq.size(), exp_hit ? 0 : 4);
    check({name, "_wr_beats"}, wq.size(), exp_wb ? 4 : 0);
    check({name, "_en_excl"}, {31'd0, both_seen}, 32'd0);
    for (int k = 0; k < rq.size() && k < 4; k++)
      check({name, "_rd_addr"}, {16'd0, rq[k]}, {16'd0, 16'(line_a + 16'(4 * k))});
    for (int k = 0; k < wq.size() && k < 4; k++) begin
      check({name, "_wb_addr"}, {16'd0, wq[k]}, {16'd0, 16'(vline_a + 16'(4 * k))});
      check({name, "_wb_data"}, wdq[k], gm[int'(vline_a >> 2) + k]);
    end

    // Architectural and residency update.
    if (is_store)
      for (int b = 0; b < 4; b++) if (be[b]) gm[gw][8*b +: 8] = d[8*b +: 8];
    if (!exp_hit) begin
      m_vld[s][slot]   = 1'b1;
      m_tag[s][slot]   = t;
      m_dirty[s][slot] = 1'b0;
    end
    stamp_ctr++;
    m_stamp[s][slot] = stamp_ctr;
    if (is_store) m_dirty[s][slot] = 1'b1;
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_data_ready"}, {31'd0, data_ready}, 32'd0);
    check({name, "_hit_miss"}, {31'd0, hit_miss}, 32'd0);
    check({name, "_data2cpu"}, data2cpu, 32'd0);
    check({name, "_data2mem"}, data2mem, 32'd0);
    check({name, "_m_rd_address"}, {16'd0, m_rd_address}, 32'd0);
    check({name, "_m_wr_address"}, {16'd0, m_wr_address}, 32'd0);
    check({name, "_mrden"}, {31'd0, mrden}, 32'd0);
    check({name, "_mwren"}, {31'd0, mwren}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic [3:0]  be;
    int          kind;
    for (int i = 0; i < MEMW; i++) begin
      sram[i] = 32'(i * 4);
      gm[i]   = 32'(i * 4);
    end
    model_clear();
    stamp_ctr   = 0;
    txn         = 0;
    data_in_mem = '0;
    rst = 1'b1; address = '0; data_in_cpu = '0; rd = 1'b0; wr = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    // Warm-up miss so that the outputs carry nonzero values before the abort.
    do_req(16'h0808, 32'd0, 4'd0, 1'b1, "warm");

    // Abort a 0x0404 fill with reset during its second FILL cycle.
    @(negedge clk);
    address = 16'h0404; rd = 1'b1;
    @(posedge clk);            // request sampled
    @(posedge clk);            // LOOKUP miss -> FILL
    @(negedge clk);
    check("abort_mrden_fill1", {31'd0, mrden}, 32'd1);
    @(posedge clk);
    @(negedge clk);            // second FILL cycle
    rst = 1'b1; rd = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero("abort");
    rst = 1'b0;
    model_clear();
`ifdef DCACHE_SA_STATS_EN
    check("stat_hits_rst", stat_hits, 32'd0);
`endif

    // Directed scenarios on set 0.
    do_req(16'h0404, 32'd0, 4'd0, 1'b1, "cold");
    check("cold_value", data2cpu, 32'h0000_0404);
    do_req(16'h0404, 32'd0, 4'd0, 1'b1, "reread");
    do_req(16'h0404, 32'h1111_1111, 4'b0011, 1'b0, "store");
    do_req(16'h0404, 32'd0, 4'd0, 1'b1, "readback");
    check("readback_value", data2cpu, 32'h0000_1111);
    do_req(16'h1404, 32'd0, 4'd0, 1'b1, "fill1");
    do_req(16'h2404, 32'd0, 4'd0, 1'b1, "fill2");
    do_req(16'h3404, 32'd0, 4'd0, 1'b1, "fill3");
    do_req(16'h4404, 32'd0, 4'd0, 1'b1, "evict");
    check("evict_value", data2cpu, 32'h0000_4404);
    if (wdq.size() > 1) check("evict_wb_word1", wdq[1], 32'h0000_1111);
    else check("evict_wb_word1_present", wdq.size(), 2);
`ifdef DCACHE_SA_STATS_EN
    check("stat_hits", stat_hits, 32'd3);
    check("stat_misses", stat_misses, 32'd5);
    check("stat_wbs", stat_wbs, 32'd1);
`endif

    // Randomized traffic over three sets with eight tags each.
    for (int i = 0; i < 150; i++) begin
      a = 16'(($urandom_range(7) << 10) | ($urandom_range(2) << 4) |
              ($urandom_range(3) << 2) | $urandom_range(3));
      kind = int'($urandom_range(3));
      be   = (kind >= 2) ? 4'($urandom_range(15, 1)) : 4'd0;
      do_req(a, $urandom, be, (kind != 2), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_sa.md
# dcache_sa

Parametrised N-way set-associative, write-back, write-allocate data cache with multi-word lines, true-LRU replacement and byte-enable writes. It sits between the CPU load/store port and the single-ported word SRAM and keeps the existing `dcache` CPU/memory port names. It generalises the direct cache to configurable sets, ways and line length. A dirty victim is written back as a burst before the line fill.

## Interface
Parameters:
- ADDR_W, 16, byte-address width (CPU and memory).
- SETS, 64, number of sets; power of 2.
- WAYS, 4, associativity; power of 2, 1..8.
- LINE_WORDS, 4, 32-bit words per line; power of 2, 1..16.

Derived address fields:
- Byte offset: [1:0], ignored.
- Word: next log2(LINE_WORDS) bits.
- Index: next log2(SETS) bits.
- Tag: remaining bits.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- address  in  ADDR_W  CPU byte address.
- data_in_cpu  in  32  store data.
- rd  in  1  load request.
- wr  in  4  store byte enables; nonzero = store.
- hit_miss  out  1  1 = request hit on first lookup; valid while data_ready.
- data2cpu  out  32  load data; valid while data_ready.
- data_ready  out  1  one-cycle completion pulse.
- data_in_mem  in  32  SRAM read data, valid 1 cycle after mrden.
- data2mem  out  32  write-back data.
- m_rd_address  out  ADDR_W  SRAM read byte address (word aligned).
- m_wr_address  out  ADDR_W  SRAM write byte address (word aligned).
- mrden  out  1  SRAM read enable.
- mwren  out  1  SRAM write enable.

## Operation
Per way:
- valid bit, dirty bit, tag, and LINE_WORDS data words.

Per set:
- log2(WAYS)-bit age per way. 0 = most recently used. Ages in a set are always a permutation.

States:
- IDLE: if `wr != 0` or `rd`, latch address, data and enables, clear `missed`, go to LOOKUP. If both rd and wr are active, the store wins. Otherwise stay.
- LOOKUP, hit:
  - Load: data2cpu <= word.
  - Store: merge bytes where wr[i]=1 and set dirty.
  - Make the hit way age 0; increment every way younger than its old age.
  - data_ready <= 1, hit_miss <= ~missed, go to DONE.
- LOOKUP, miss:
  - Set `missed`.
  - Victim = lowest-index invalid way, else the way with age WAYS-1.
  - If the victim is valid and dirty, go to WB; else go to FILL.
- WB: LINE_WORDS cycles with mwren=1. m_wr_address = {victim tag, index, word k, 2'b00} for k=0..LINE_WORDS-1 ascending; data2mem = victim word k. Then go to FILL.
- FILL:
  - mrden=1 for LINE_WORDS cycles; m_rd_address = {req tag, index, k, 2'b00} ascending.
  - Word k is captured from data_in_mem in the cycle after its read.
  - After the last capture: tag <= req tag, valid <= 1, dirty <= 0. Go to LOOKUP (replay, which hits).
- DONE: data_ready=1 this cycle only; inputs ignored. Go to IDLE.

General rules:
- The CPU holds the request stable from the IDLE sample until data_ready.
- mrden and mwren are never asserted together.
- Memory addresses outside WB/FILL are don't-care; the enables are 0.

## Timing
Reset:
- On rst, next edge: all valid=0, dirty=0, ages[w]=w, state IDLE.
- hit_miss, data2cpu, data_ready, data2mem, m_rd_address, m_wr_address, mrden, mwren = 0.

Latency, in edges from the IDLE sampling edge to data_ready high:
- Hit: 1 (data_ready high in the cycle after LOOKUP).
- Clean miss: LINE_WORDS+3.
- Dirty miss: 2·LINE_WORDS+3.

Handshake:
- A new request is sampled no earlier than the edge after data_ready falls.
- Back-to-back hits: one request per 3 cycles.

Boundary cases:
- rst mid-WB: abort; memory may hold a partial line.
- rst mid-FILL: abort; the partial line is discarded (valid stays 0).
- WAYS=1: degenerates to direct-mapped; age logic is unused.
- Address bits [1:0] are ignored; no alignment fault.

## Configuration
- DCACHE_SA_STATS_EN defined: adds output ports stat_hits, stat_misses, stat_wbs (32 bits each).
  - Cleared by rst; wrap modulo 2^32.
  - Incremented once per CPU request on the first LOOKUP (hit or miss), and once per WB entry.
  - Replay lookups are not counted.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
Defaults throughout. SRAM preloaded mem[a] = a. Set 0 uses tags from 0x0404/0x1404/0x2404/0x3404/0x4404.
- Cold read of 0x0404: mrden for 4 cycles at 0x0400, 0x0404, 0x0408, 0x040C. Then data2cpu=0x00000404, hit_miss=0, data_ready 7 edges after sample.
- Re-read of 0x0404: hit_miss=1, data2cpu=0x00000404, no mrden/mwren, data_ready 1 edge after sample.
- Store 0x11111111 with wr=4'b0011 to 0x0404, then read: data2cpu=0x00001111, hit_miss=1, no mwren.
- Read 0x1404, 0x2404, 0x3404 (3 misses), then 0x4404:
  - Victim is the 0x0404 line (LRU, dirty).
  - mwren for 4 cycles at 0x0400..0x040C; data2mem word1 = 0x00001111.
  - Then 4-word fill; data2cpu=0x00004404, latency 11 edges.
- rst pulsed during the 2nd FILL cycle of a 0x0404 miss: next cycle all outputs 0. A subsequent read of 0x0404 misses (hit_miss=0).
- With DCACHE_SA_STATS_EN, after the first four scenarios: stat_hits=3, stat_misses=5, stat_wbs=1.
